// File: rtl/ras_ctrl_if.sv
// rtl/ras_ctrl_if.sv - fetch, return-stack and prediction signal bundle for ras_ctrl
interface ras_ctrl_if;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_ready;
    logic        flush;
    logic        ras_push;
    logic        ras_pop;
    logic [31:0] ras_pc_in;
    logic [31:0] ras_pc_out;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic        pred_taken;

    modport master (
        output if_valid, if_pc, if_instr, flush, ras_pc_out,
        input  if_ready, ras_push, ras_pop, ras_pc_in, pred_valid, pred_pc, pred_taken
    );

    modport slave (
        input  if_valid, if_pc, if_instr, flush, ras_pc_out,
        output if_ready, ras_push, ras_pop, ras_pc_in, pred_valid, pred_pc, pred_taken
    );
endinterface

// File: rtl/ras_ctrl.sv
// rtl/ras_ctrl.sv - return-address-stack controller: classifies jumps, drives push/pop and next-PC prediction
// Optional RAS_CTRL_COROUTINE_EN: coroutine swap (pop then push) via a PUSH2 state.
module ras_ctrl (
    input  logic      clk,
    input  logic      reset,
    ras_ctrl_if.slave bus
);
    localparam logic [5:0] DEPTH_MAX = 6'd32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1
`ifdef RAS_CTRL_COROUTINE_EN
        , PUSH2 = 2'd2
`endif
    } state_t;

    typedef enum logic [2:0] {
        CL_NONE     = 3'd0,
        CL_CALL     = 3'd1,
        CL_CALL_IND = 3'd2,
        CL_RET      = 3'd3,
        CL_CORO     = 3'd4
    } cls_t;

    function automatic cls_t classify(input logic [31:0] instr);
        logic [4:0] rd;
        logic [4:0] rs1;
        logic       rd_link;
        logic       rs1_link;
        cls_t       cls;
        rd       = instr[11:7];
        rs1      = instr[19:15];
        rd_link  = (rd == 5'd1) || (rd == 5'd5);
        rs1_link = (rs1 == 5'd1) || (rs1 == 5'd5);
        cls      = CL_NONE;
        if (instr[6:0] == 7'b1101111) begin
            cls = rd_link ? CL_CALL : CL_NONE;
        end else if (instr[6:0] == 7'b1100111 && instr[14:12] == 3'b000) begin
            if (rd_link && rs1_link && (rd != rs1)) begin
`ifdef RAS_CTRL_COROUTINE_EN
                cls = CL_CORO;
`else
                cls = CL_CALL_IND;
`endif
            end else if (rd_link) begin
                cls = CL_CALL_IND;
            end else if (rs1_link) begin
                cls = CL_RET;
            end
        end
        return cls;
    endfunction

    function automatic logic [31:0] j_imm(input logic [31:0] instr);
        return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    endfunction

    state_t      state_q, state_d;
    cls_t        cls_q, cls_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] jimm_q, jimm_d;
    logic [5:0]  depth_q, depth_d;

    logic        if_ready_c;
    logic        push_c;
    logic        pop_c;
    logic        pv_c;
    logic [31:0] ppc_c;
    logic        pt_c;
    logic        accept;
    logic [31:0] pc_plus4;
`ifdef RAS_CTRL_COROUTINE_EN
    logic        coro_issue;
`endif

    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        if_ready_c = 1'b0;
        push_c     = 1'b0;
        pop_c      = 1'b0;
        pv_c       = 1'b0;
        ppc_c      = '0;
        pt_c       = 1'b0;
`ifdef RAS_CTRL_COROUTINE_EN
        coro_issue = 1'b0;
`endif
        case (state_q)
            IDLE: if_ready_c = 1'b1;
            ISSUE: begin
                if_ready_c = 1'b1;
                pv_c       = 1'b1;
                ppc_c      = pc_plus4;
                case (cls_q)
                    CL_CALL: begin
                        push_c = 1'b1;
                        ppc_c  = pc_q + jimm_q;
                        pt_c   = 1'b1;
                    end
                    CL_CALL_IND: push_c = 1'b1;
                    CL_RET: begin
                        if (depth_q != 6'd0) begin
                            pop_c = 1'b1;
                            ppc_c = bus.ras_pc_out;
                            pt_c  = 1'b1;
                        end
                    end
`ifdef RAS_CTRL_COROUTINE_EN
                    CL_CORO: begin
                        // Fetch stalls one cycle while the second push goes out.
                        coro_issue = 1'b1;
                        if_ready_c = 1'b0;
                        if (depth_q != 6'd0) begin
                            pop_c = 1'b1;
                            ppc_c = bus.ras_pc_out;
                            pt_c  = 1'b1;
                        end
                    end
`endif
                    default: ;
                endcase
            end
`ifdef RAS_CTRL_COROUTINE_EN
            PUSH2: begin
                if_ready_c = 1'b1;
                push_c     = 1'b1;
            end
`endif
            default: ;
        endcase
        if (reset || bus.flush) begin
            if_ready_c = 1'b0;
            push_c     = 1'b0;
            pop_c      = 1'b0;
            pv_c       = 1'b0;
            ppc_c      = '0;
            pt_c       = 1'b0;
        end
    end

    assign accept = bus.if_valid && if_ready_c;

    always_comb begin
        state_d = IDLE;
        cls_d   = cls_q;
        pc_d    = pc_q;
        jimm_d  = jimm_q;
        depth_d = depth_q;
        // Saturation only stops the count; the push itself still reaches the stack.
        if (push_c && depth_q != DEPTH_MAX) begin
            depth_d = depth_q + 6'd1;
        end else if (pop_c) begin
            depth_d = depth_q - 6'd1;
        end
        if (!bus.flush) begin
`ifdef RAS_CTRL_COROUTINE_EN
            if (coro_issue) state_d = PUSH2;
            else
`endif
            if (accept) begin
                state_d = ISSUE;
                cls_d   = classify(bus.if_instr);
                pc_d    = bus.if_pc;
                jimm_d  = j_imm(bus.if_instr);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cls_q   <= CL_NONE;
            pc_q    <= '0;
            jimm_q  <= '0;
            depth_q <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            pc_q    <= pc_d;
            jimm_q  <= jimm_d;
            depth_q <= depth_d;
        end
    end

    assign bus.if_ready   = if_ready_c;
    assign bus.ras_push   = push_c;
    assign bus.ras_pop    = pop_c;
    assign bus.ras_pc_in  = push_c ? pc_plus4 : 32'd0;
    assign bus.pred_valid = pv_c;
    assign bus.pred_pc    = ppc_c;
    assign bus.pred_taken = pt_c;
endmodule

// File: tb/tb_ras_ctrl.sv
// tb/tb_ras_ctrl.sv - randomized and directed checks of ras_ctrl against a transaction-level model
module tb_ras_ctrl;
`ifdef RAS_CTRL_COROUTINE_EN
    localparam bit CORO_EN = 1'b1;
`else
    localparam bit CORO_EN = 1'b0;
`endif
    localparam int K_NONE = 0, K_CALL = 1, K_CALL_IND = 2, K_RET = 3, K_CORO = 4;
    localparam logic [31:0] JAL_X1 = 32'h040000EF;
    localparam logic [31:0] RET_I  = 32'h00008067;
    localparam logic [31:0] CORO_I = 32'h000280E7;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    ras_ctrl_if bus ();
    ras_ctrl dut (.clk(clk), .reset(reset), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%h required=0x%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int mclass(input logic [31:0] w);
        int  rd, rs1;
        bit  lrd, lrs1;
        rd   = int'(w[11:7]);
        rs1  = int'(w[19:15]);
        lrd  = (rd == 1) || (rd == 5);
        lrs1 = (rs1 == 1) || (rs1 == 5);
        if (w[6:0] == 7'h6f) return lrd ? K_CALL : K_NONE;
        if (w[6:0] != 7'h67 || w[14:12] != 3'd0) return K_NONE;
        if (lrd && lrs1 && rd != rs1) return CORO_EN ? K_CORO : K_CALL_IND;
        if (lrd) return K_CALL_IND;
        if (lrs1) return K_RET;
        return K_NONE;
    endfunction

    function automatic logic [31:0] mjimm(input logic [31:0] w);
        logic [20:0] imm;
        imm = {w[31], w[19:12], w[20], w[30:21], 1'b0};
        return 32'($signed(imm));
    endfunction

    // Model state: an accepted instruction awaiting its issue cycle, a pending coroutine push.
    bit          m_pend = 0, m_second = 0;
    int          m_cls = K_NONE, m_depth = 0;
    logic [31:0] m_pc = 0, m_jimm = 0;

    initial begin
        bit e_rdy, e_push, e_pop, e_pv, e_pt;
        logic [31:0] e_pcin, e_ppc;
        forever begin
            @(negedge clk);
            e_rdy = 0; e_push = 0; e_pop = 0; e_pv = 0; e_pt = 0; e_pcin = 0; e_ppc = 0;
            if (!reset && !bus.flush) begin
                e_rdy = 1;
                if (m_pend) begin
                    e_pv  = 1;
                    e_ppc = m_pc + 32'd4;
                    if (m_cls == K_CALL) begin
                        e_push = 1; e_ppc = m_pc + m_jimm; e_pt = 1;
                    end else if (m_cls == K_CALL_IND) begin
                        e_push = 1;
                    end else if (m_cls == K_RET || m_cls == K_CORO) begin
                        if (m_depth > 0) begin
                            e_pop = 1; e_ppc = bus.ras_pc_out; e_pt = 1;
                        end
                        if (m_cls == K_CORO) e_rdy = 0;
                    end
                end else if (m_second) begin
                    e_push = 1;
                end
                if (e_push) e_pcin = m_pc + 32'd4;
            end
            chk("if_ready", 32'(bus.if_ready), 32'(e_rdy));
            chk("ras_push", 32'(bus.ras_push), 32'(e_push));
            chk("ras_pop", 32'(bus.ras_pop), 32'(e_pop));
            chk("ras_pc_in", bus.ras_pc_in, e_pcin);
            chk("pred_valid", 32'(bus.pred_valid), 32'(e_pv));
            chk("push_pop_exclusive", 32'(bus.ras_push && bus.ras_pop), 32'd0);
            if (e_pv || reset) begin
                chk("pred_pc", bus.pred_pc, e_ppc);
                chk("pred_taken", 32'(bus.pred_taken), 32'(e_pt));
            end
            if (!reset) chk("depth", 32'(dut.depth_q), 32'(m_depth));
            @(posedge clk);
            if (reset) begin
                m_pend = 0; m_second = 0; m_depth = 0; m_pc = 0; m_jimm = 0; m_cls = K_NONE;
            end else if (bus.flush) begin
                m_pend = 0; m_second = 0;
            end else begin
                if (e_push) m_depth = (m_depth < 32) ? m_depth + 1 : 32;
                if (e_pop) m_depth = m_depth - 1;
                m_second = m_pend && (m_cls == K_CORO);
                m_pend   = bus.if_valid && e_rdy;
                if (m_pend) begin
                    m_pc   = bus.if_pc;
                    m_cls  = mclass(bus.if_instr);
                    m_jimm = mjimm(bus.if_instr);
                end
            end
        end
    end

    task automatic drive(input bit v, input logic [31:0] pc, input logic [31:0] ins);
        @(posedge clk);
        #1;
        bus.if_valid = v;
        bus.if_pc    = pc;
        bus.if_instr = ins;
    endtask

    task automatic look();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [4:0] rreg();
        case ($urandom % 4)
            0: return 5'd0;
            1: return 5'd1;
            2: return 5'd5;
            default: return 5'($urandom);
        endcase
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom % 4)
            0: return {r[31:12], rreg(), 7'h6f};
            1, 2: return {r[31:20], rreg(), 3'b000, rreg(), 7'h67};
            default: return {r[31:7], 7'h13};
        endcase
    endfunction

    initial begin
        reset = 1'b1;
        bus.if_valid = 1'b1; bus.if_pc = 32'h100; bus.if_instr = JAL_X1;
        bus.flush = 1'b0; bus.ras_pc_out = 32'h0;
        chk("model_jimm_pos", mjimm(JAL_X1), 32'h40);
        chk("model_jimm_neg", mjimm(32'hFFDFF0EF), 32'hFFFFFFFC);
        chk("model_class_coro", 32'(mclass(CORO_I)), CORO_EN ? 32'(K_CORO) : 32'(K_CALL_IND));
        look();
        chk("rst_if_ready", 32'(bus.if_ready), 0);
        chk("rst_pred_pc", bus.pred_pc, 0);
        chk("rst_ras_push", 32'(bus.ras_push), 0);

        drive(1, 32'h100, JAL_X1); reset = 1'b0;
        look(); chk("idle_ready", 32'(bus.if_ready), 1);
        drive(1, 32'h200, RET_I); bus.ras_pc_out = 32'h104;
        look();
        chk("call_push", 32'(bus.ras_push), 1);
        chk("call_pc_in", bus.ras_pc_in, 32'h104);
        chk("call_pred_pc", bus.pred_pc, 32'h140);
        chk("call_taken", 32'(bus.pred_taken), 1);
        drive(0, 0, 0); look();
        chk("call_depth", 32'(dut.depth_q), 1);
        chk("ret_pop", 32'(bus.ras_pop), 1);
        chk("ret_pred_pc", bus.pred_pc, 32'h104);
        chk("ret_taken", 32'(bus.pred_taken), 1);
        drive(1, 32'h300, RET_I); look();
        chk("ret_depth", 32'(dut.depth_q), 0);
        drive(0, 0, 0); look();
        chk("empty_ret_pop", 32'(bus.ras_pop), 0);
        chk("empty_ret_valid", 32'(bus.pred_valid), 1);
        chk("empty_ret_pred_pc", bus.pred_pc, 32'h304);
        chk("empty_ret_taken", 32'(bus.pred_taken), 0);

        drive(1, 32'h380, JAL_X1);
        drive(0, 0, 0);
        drive(1, 32'h400, CORO_I); bus.ras_pc_out = 32'h500;
        drive(0, 0, 0); look();
`ifdef RAS_CTRL_COROUTINE_EN
        chk("coro_pop", 32'(bus.ras_pop), 1);
        chk("coro_pred_pc", bus.pred_pc, 32'h500);
        chk("coro_ready", 32'(bus.if_ready), 0);
        drive(0, 0, 0); look();
        chk("coro_push2", 32'(bus.ras_push), 1);
        chk("coro_push2_pc_in", bus.ras_pc_in, 32'h404);
`else
        chk("coro_as_ind_push", 32'(bus.ras_push), 1);
        chk("coro_as_ind_pc_in", bus.ras_pc_in, 32'h404);
        chk("coro_as_ind_taken", 32'(bus.pred_taken), 0);
        chk("coro_as_ind_ready", 32'(bus.if_ready), 1);
`endif

        for (int i = 0; i < 33; i++) begin
            drive(1, 32'h1000 + 32'(i) * 4, JAL_X1);
            if (i > 0) begin
                look(); chk("b2b_push", 32'(bus.ras_push), 1);
            end
        end
        drive(0, 0, 0); look(); chk("b2b_last_push", 32'(bus.ras_push), 1);
        drive(0, 0, 0); look(); chk("sat_depth", 32'(dut.depth_q), 32);
        drive(1, 32'h2000, JAL_X1);
        drive(0, 0, 0); bus.flush = 1'b1; look();
        chk("flush_push", 32'(bus.ras_push), 0);
        chk("flush_valid", 32'(bus.pred_valid), 0);
        chk("flush_ready", 32'(bus.if_ready), 0);
        drive(0, 0, 0); bus.flush = 1'b0; look();
        chk("flush_depth", 32'(dut.depth_q), 32);

        drive(1, 32'h3000, CORO_I);
        drive(0, 0, 0);
`ifdef RAS_CTRL_COROUTINE_EN
        drive(0, 0, 0);
`endif
        reset = 1'b1; look();
        chk("rst_mid_push", 32'(bus.ras_push), 0);
        chk("rst_mid_valid", 32'(bus.pred_valid), 0);
        drive(0, 0, 0); reset = 1'b0; look();
        chk("rst_after_depth", 32'(dut.depth_q), 0);
        chk("rst_after_push", 32'(bus.ras_push), 0);
        chk("rst_after_pop", 32'(bus.ras_pop), 0);
        drive(0, 0, 0); look(); chk("rst_later_push", 32'(bus.ras_push), 0);

        for (int i = 0; i < 3000; i++) begin
            drive(($urandom % 4) != 0, $urandom & 32'hFFFF_FFFC, rnd_instr());
            bus.flush      = ($urandom % 20) == 0;
            reset          = ($urandom % 100) == 0;
            bus.ras_pc_out = $urandom;
        end
        drive(0, 0, 0); bus.flush = 1'b0; reset = 1'b0;
        drive(0, 0, 0);
        drive(0, 0, 0);
        look();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ras_ctrl.md
RAS_CTRL -- requirements
Module: ras_ctrl

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 if_valid  in  1  fetch presents an instruction this cycle.
REQ-004 if_pc  in  32  PC of presented instruction.
REQ-005 if_instr  in  32  raw RV32 instruction word.
REQ-006 if_ready  out  1  block accepts; transfer occurs when if_valid && if_ready.
REQ-007 flush  in  1  pipeline redirect; discards in-flight work.
REQ-008 ras_push  out  1  one-cycle push pulse to ras_stack.push.
REQ-009 ras_pop  out  1  one-cycle pop pulse to ras_stack.pop.
REQ-010 ras_pc_in  out  32  return address to ras_stack.pc_in.
REQ-011 ras_pc_out  in  32  top-of-stack value from ras_stack.pc_out, valid combinationally in the ras_pop cycle.
REQ-012 pred_valid  out  1  prediction for last accepted instruction is valid this cycle.
REQ-013 pred_pc  out  32  predicted next PC.
REQ-014 pred_taken  out  1  1 = redirect to pred_pc; 0 = sequential.

Function
REQ-015 Link register = x1 or x5; classification on accept: JAL rd=link -> CALL; JALR rd!=link, rs1=link -> RET; JALR rd=link, rs1!=link -> CALL_IND; JALR rd=link, rs1=link, rd!=rs1 -> CORO; JALR rd=rs1=link -> CALL_IND; all else -> NONE.
REQ-016 FSM states IDLE, ISSUE, PUSH2; accept in IDLE or ISSUE latches pc, class, J-immediate and enters ISSUE next cycle.
REQ-017 ISSUE lasts one cycle, drives pred_valid=1 and per class: CALL push, pred_pc=pc+Jimm, taken=1; CALL_IND push, pred_pc=pc+4, taken=0; RET pop, pred_pc=ras_pc_out, taken=1; CORO pop, pred_pc=ras_pc_out, taken=1; NONE no push/pop, pred_pc=pc+4, taken=0.
REQ-018 ras_pc_in = latched pc+4 whenever ras_push=1, else 0.
REQ-019 Latency: accept in cycle N -> push/pop/pred in cycle N+1; throughput one instruction per cycle except CORO.
REQ-020 CORO: ISSUE -> PUSH2; if_ready=0 in ISSUE; PUSH2 drives ras_push=1, ras_pc_in=pc+4, pred_valid=0, if_ready=1.
REQ-021 Exit of ISSUE (non-CORO) or PUSH2: accept -> ISSUE, else IDLE.
REQ-022 Depth counter 0..32 tracks stack occupancy: +1 per ras_push saturating at 32 (push still issued), -1 per ras_pop.
REQ-023 RET/CORO with counter=0: ras_pop suppressed, pred_pc=pc+4, taken=0; CORO still proceeds to PUSH2.
REQ-024 All arithmetic modulo 2^32; J-immediate is 21-bit sign-extended.
REQ-025 flush=1: if_ready=0, ras_push, ras_pop, pred_valid forced 0 same cycle; next state IDLE; counter unchanged.
REQ-026 ras_push and ras_pop never both 1 in one cycle.

Reset
REQ-027 reset=1: state IDLE, counter 0, all latched fields 0; reset has priority over flush and accept.
REQ-028 During reset: if_ready=0, ras_push=0, ras_pop=0, ras_pc_in=0, pred_valid=0, pred_pc=0, pred_taken=0.
REQ-029 Reset mid-PUSH2 or mid-ISSUE abandons the operation; no push/pop pulse in any later cycle.

Configuration
REQ-030 Macro RAS_CTRL_COROUTINE_EN defined: CORO classified and handled per REQ-017/REQ-020.
REQ-031 Macro undefined: CORO treated as CALL_IND (single push, not taken); PUSH2 state absent; if_ready never deasserted except reset/flush.

Verification
REQ-032 Reset, then JAL x1,+0x40 (0x040000EF) at 0x100 -> N+1: ras_push=1, ras_pc_in=0x104, pred_pc=0x140, pred_taken=1, counter=1.
REQ-033 Then jalr x0,0(x1) (0x00008067) at 0x200, ras_pc_out=0x104 -> N+1: ras_pop=1, pred_pc=0x104, pred_taken=1, counter=0.
REQ-034 RET at 0x300 with counter=0 -> ras_pop=0, pred_valid=1, pred_pc=0x304, pred_taken=0.
REQ-035 COROUTINE_EN, counter=1: jalr x1,0(x5) (0x000280E7) at 0x400, ras_pc_out=0x500 -> N+1 ras_pop=1, pred_pc=0x500, if_ready=0; N+2 ras_push=1, ras_pc_in=0x404.
REQ-036 33 back-to-back JAL x1 -> ras_push every cycle, counter saturates at 32; flush in an ISSUE cycle -> no pulse, counter unchanged.
REQ-037 reset asserted in PUSH2 -> no ras_push in that or any later cycle; all outputs 0, counter 0.
